// File: rtl/escalonador_bluetooth.sv
// Scheduler between the control unit and the sensor/Bluetooth datapath: sample tick,
// rain-sensor debounce, UART status frame (letra, CR, LF) and timed Bluetooth reset pulse.
module escalonador_bluetooth #(
  parameter int PERIODO_AMOSTRA = 50000000,
  parameter int DEBOUNCE        = 4,
  parameter int RESET_CICLOS    = 1000
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       flag_ler,
  input  logic       enable_blue,
  input  logic       reset_blue,
  input  logic [7:0] letra,
  input  logic       sensor_in,
  input  logic       tx_ready,
  output logic       tx_valid,
  output logic [7:0] tx_data,
  output logic       saida_buffer,
  output logic       bt_reset_n,
  output logic       ocupado,
  output logic       overrun
);

  localparam int TW = $clog2(PERIODO_AMOSTRA);
  localparam int DW = $clog2(DEBOUNCE + 1);
  localparam int RW = $clog2(RESET_CICLOS + 1);
  localparam logic [TW-1:0] TICK_MAX = TW'(PERIODO_AMOSTRA - 1);
  localparam logic [DW-1:0] DEB_MAX  = DW'(DEBOUNCE);
  localparam logic [RW-1:0] RST_MAX  = RW'(RESET_CICLOS - 1);

  typedef enum logic [2:0] {IDLE, TX_CHAR, TX_CR, TX_LF, BT_RESET} state_t;

  // Handshake: a byte transfers on every rising clk edge where tx_valid && tx_ready;
  // tx_valid and tx_data are held unchanged until that edge.

  state_t          state, state_n;
  logic [TW-1:0]   tick_cnt;
  logic            tick;
  logic            sync_q1, sync_q2;
  logic            cand;
  logic [DW-1:0]   deb_cnt, deb_inc;
  logic            rb_q, pend_q, rise;
  logic [RW-1:0]   bt_cnt;
  logic [7:0]      letra_q;
  logic            start_frame, take_reset;

  assign tick    = (tick_cnt == TICK_MAX);
  assign deb_inc = deb_cnt + DW'(1);
  assign rise    = reset_blue & ~rb_q;

  always_ff @(posedge clk) begin
    if (reset) begin
      tick_cnt <= '0;
      sync_q1  <= 1'b1;
      sync_q2  <= 1'b1;
    end else begin
      tick_cnt <= tick ? '0 : tick_cnt + TW'(1);
      sync_q1  <= sensor_in;
      sync_q2  <= sync_q1;
    end
  end

  // Count saturates at DEBOUNCE; once there, saida_buffer already equals cand.
  always_ff @(posedge clk) begin
    if (reset) begin
      cand         <= 1'b1;
      deb_cnt      <= '0;
      saida_buffer <= 1'b1;
    end else if (tick && flag_ler) begin
      if (sync_q2 == cand) begin
        if (deb_cnt != DEB_MAX) begin
          deb_cnt <= deb_inc;
          if (deb_inc == DEB_MAX) saida_buffer <= cand;
        end
      end else begin
        cand    <= sync_q2;
        deb_cnt <= DW'(1);
        if (DW'(1) == DEB_MAX) saida_buffer <= sync_q2;
      end
    end
  end

  always_comb begin
    state_n     = state;
    start_frame = 1'b0;
    take_reset  = 1'b0;
    case (state)
      IDLE: begin
        if (pend_q) begin
          state_n    = BT_RESET;
          take_reset = 1'b1;
        end else if (tick && enable_blue) begin
          state_n     = TX_CHAR;
          start_frame = 1'b1;
        end
      end
      TX_CHAR:  if (tx_ready) state_n = TX_CR;
      TX_CR:    if (tx_ready) state_n = TX_LF;
      TX_LF:    if (tx_ready) state_n = IDLE;
      BT_RESET: if (bt_cnt == RST_MAX) state_n = IDLE;
      default:  state_n = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state   <= IDLE;
      ocupado <= 1'b0;
      letra_q <= 8'h00;
      bt_cnt  <= '0;
      rb_q    <= 1'b0;
      pend_q  <= 1'b0;
      overrun <= 1'b0;
    end else begin
      state   <= state_n;
      ocupado <= (state_n != IDLE);
      rb_q    <= reset_blue;
      if (start_frame) letra_q <= letra;
      bt_cnt  <= (state == BT_RESET) ? bt_cnt + RW'(1) : '0;
      // Taking the request wins over a coincident edge; edges are ignored while pending or resetting.
      if (take_reset)
        pend_q <= 1'b0;
      else if (rise && state != BT_RESET)
        pend_q <= 1'b1;
      if (tick && enable_blue && (state != IDLE || pend_q))
        overrun <= 1'b1;
    end
  end

  always_comb begin
    tx_valid = 1'b0;
    tx_data  = 8'h00;
    case (state)
      TX_CHAR: begin tx_valid = 1'b1; tx_data = letra_q; end
      TX_CR:   begin tx_valid = 1'b1; tx_data = 8'h0D;   end
      TX_LF:   begin tx_valid = 1'b1; tx_data = 8'h0A;   end
      default: begin tx_valid = 1'b0; tx_data = 8'h00;   end
    endcase
  end

  assign bt_reset_n = (state != BT_RESET);

endmodule

// File: tb/tb_escalonador_bluetooth.sv
// Directed bench for escalonador_bluetooth with PERIODO_AMOSTRA=8, DEBOUNCE=3, RESET_CICLOS=5.
module tb_escalonador_bluetooth;

  logic       clk = 1'b0;
  logic       reset;
  logic       flag_ler;
  logic       enable_blue;
  logic       reset_blue;
  logic [7:0] letra;
  logic       sensor_in;
  logic       tx_ready;
  logic       tx_valid;
  logic [7:0] tx_data;
  logic       saida_buffer;
  logic       bt_reset_n;
  logic       ocupado;
  logic       overrun;

  int total = 0;
  int bad   = 0;

  // Reference sample counter: value 7 marks the cycle in which the tick is high.
  logic [2:0] m;

  escalonador_bluetooth #(
    .PERIODO_AMOSTRA(8),
    .DEBOUNCE(3),
    .RESET_CICLOS(5)
  ) dut (
    .clk(clk),
    .reset(reset),
    .flag_ler(flag_ler),
    .enable_blue(enable_blue),
    .reset_blue(reset_blue),
    .letra(letra),
    .sensor_in(sensor_in),
    .tx_ready(tx_ready),
    .tx_valid(tx_valid),
    .tx_data(tx_data),
    .saida_buffer(saida_buffer),
    .bt_reset_n(bt_reset_n),
    .ocupado(ocupado),
    .overrun(overrun)
  );

  // clock / reset block
  always #5 clk = ~clk;

  always @(posedge clk) begin
    if (reset) m <= 3'd0;
    else       m <= m + 3'd1;
  end

  initial begin
    #200000;
    $display("FAIL timeout observed=running expected=finished");
    $fatal(1, "time limit");
  end

  // driver tasks
  task automatic step(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic to_tick();
    int n;
    n = 0;
    while (m != 3'd7 && n < 16) begin
      step(1);
      n++;
    end
  endtask

  task automatic chk1(input string tag, input logic obs, input logic exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%b expected=%b", tag, obs, exp);
    end
  endtask

  task automatic chk8(input string tag, input logic [7:0] obs, input logic [7:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  initial begin
    reset       = 1'b1;
    flag_ler    = 1'b0;
    enable_blue = 1'b0;
    reset_blue  = 1'b0;
    letra       = 8'h00;
    sensor_in   = 1'b1;
    tx_ready    = 1'b0;
    step(3);

    // reset state
    chk1("rst_tx_valid", tx_valid, 1'b0);
    chk8("rst_tx_data", tx_data, 8'h00);
    chk1("rst_saida", saida_buffer, 1'b1);
    chk1("rst_bt_reset_n", bt_reset_n, 1'b1);
    chk1("rst_ocupado", ocupado, 1'b0);
    chk1("rst_overrun", overrun, 1'b0);
    reset = 1'b0;

    // idle: nothing moves
    for (int i = 0; i < 20; i++) begin
      step(1);
      chk1("idle_tx_valid", tx_valid, 1'b0);
      chk1("idle_bt_reset_n", bt_reset_n, 1'b1);
      chk1("idle_saida", saida_buffer, 1'b1);
      chk1("idle_overrun", overrun, 1'b0);
    end

    // debounce: sensor low held, falls on the third tick
    to_tick();
    step(1);
    flag_ler  = 1'b1;
    sensor_in = 1'b0;
    to_tick();
    step(1);
    chk1("deb_tick1", saida_buffer, 1'b1);
    to_tick();
    step(1);
    chk1("deb_tick2", saida_buffer, 1'b1);
    to_tick();
    chk1("deb_pre_tick3", saida_buffer, 1'b1);
    step(1);
    chk1("deb_tick3", saida_buffer, 1'b0);

    // one-tick glitch back to 1 does not change the output
    sensor_in = 1'b1;
    to_tick();
    step(1);
    chk1("deb_glitch", saida_buffer, 1'b0);
    sensor_in = 1'b0;
    for (int i = 0; i < 3; i++) begin
      to_tick();
      step(1);
      chk1("deb_after_glitch", saida_buffer, 1'b0);
    end

    // flag_ler low: debouncer holds
    flag_ler  = 1'b0;
    sensor_in = 1'b1;
    for (int i = 0; i < 4; i++) begin
      to_tick();
      step(1);
      chk1("deb_hold", saida_buffer, 1'b0);
    end

    // frame with ready always high
    enable_blue = 1'b1;
    letra       = 8'h43;
    tx_ready    = 1'b1;
    to_tick();
    chk1("f1_pre_valid", tx_valid, 1'b0);
    step(1);
    chk1("f1_char_valid", tx_valid, 1'b1);
    chk8("f1_char_data", tx_data, 8'h43);
    chk1("f1_ocupado", ocupado, 1'b1);
    letra = 8'h55;
    chk8("f1_char_latched", tx_data, 8'h43);
    step(1);
    chk1("f1_cr_valid", tx_valid, 1'b1);
    chk8("f1_cr_data", tx_data, 8'h0D);
    step(1);
    chk1("f1_lf_valid", tx_valid, 1'b1);
    chk8("f1_lf_data", tx_data, 8'h0A);
    enable_blue = 1'b0;
    step(1);
    chk1("f1_end_valid", tx_valid, 1'b0);
    chk1("f1_end_ocupado", ocupado, 1'b0);
    chk1("f1_overrun", overrun, 1'b0);

    // backpressure during CR, tick meanwhile sets overrun
    letra       = 8'h52;
    enable_blue = 1'b1;
    to_tick();
    step(1);
    chk8("f2_char_data", tx_data, 8'h52);
    step(1);
    chk8("f2_cr_data", tx_data, 8'h0D);
    tx_ready = 1'b0;
    for (int i = 0; i < 10; i++) begin
      step(1);
      chk1("f2_stall_valid", tx_valid, 1'b1);
      chk8("f2_stall_data", tx_data, 8'h0D);
    end
    enable_blue = 1'b0;
    chk1("f2_overrun_set", overrun, 1'b1);
    tx_ready = 1'b1;
    step(1);
    chk8("f2_lf_data", tx_data, 8'h0A);
    step(1);
    chk1("f2_end_valid", tx_valid, 1'b0);
    chk1("f2_end_ocupado", ocupado, 1'b0);
    for (int i = 0; i < 10; i++) begin
      step(1);
      chk1("f2_no_queued_frame", tx_valid, 1'b0);
    end
    chk1("f2_overrun_sticky", overrun, 1'b1);

    // reset request mid-frame is served after the frame
    enable_blue = 1'b1;
    letra       = 8'h41;
    to_tick();
    step(1);
    chk8("f3_char_data", tx_data, 8'h41);
    reset_blue  = 1'b1;
    enable_blue = 1'b0;
    step(1);
    chk8("f3_cr_data", tx_data, 8'h0D);
    chk1("f3_cr_bt", bt_reset_n, 1'b1);
    step(1);
    chk8("f3_lf_data", tx_data, 8'h0A);
    step(1);
    chk1("f3_idle_valid", tx_valid, 1'b0);
    chk1("f3_idle_bt", bt_reset_n, 1'b1);
    step(1);
    for (int i = 0; i < 5; i++) begin
      chk1("bt_pulse_low", bt_reset_n, 1'b0);
      chk1("bt_pulse_valid", tx_valid, 1'b0);
      chk1("bt_pulse_ocupado", ocupado, 1'b1);
      step(1);
    end
    chk1("bt_pulse_end", bt_reset_n, 1'b1);
    chk1("bt_pulse_end_ocupado", ocupado, 1'b0);
    for (int i = 0; i < 10; i++) begin
      step(1);
      chk1("bt_no_retrigger", bt_reset_n, 1'b1);
    end

    // reset during BT_RESET
    reset_blue = 1'b0;
    step(1);
    reset_blue = 1'b1;
    step(1);
    step(1);
    chk1("r1_in_bt", bt_reset_n, 1'b0);
    reset      = 1'b1;
    reset_blue = 1'b0;
    step(1);
    chk1("r1_bt", bt_reset_n, 1'b1);
    chk1("r1_valid", tx_valid, 1'b0);
    chk1("r1_ocupado", ocupado, 1'b0);
    chk1("r1_overrun", overrun, 1'b0);
    reset = 1'b0;
    for (int i = 0; i < 8; i++) begin
      step(1);
      chk1("r1_no_pending", bt_reset_n, 1'b1);
    end

    // reset during TX_LF
    enable_blue = 1'b1;
    letra       = 8'h44;
    tx_ready    = 1'b1;
    to_tick();
    step(1);
    chk8("r2_char_data", tx_data, 8'h44);
    enable_blue = 1'b0;
    step(1);
    step(1);
    chk8("r2_lf_data", tx_data, 8'h0A);
    reset = 1'b1;
    step(1);
    chk1("r2_valid", tx_valid, 1'b0);
    chk1("r2_ocupado", ocupado, 1'b0);
    chk1("r2_bt", bt_reset_n, 1'b1);
    reset = 1'b0;
    step(1);
    chk1("r2_valid_after", tx_valid, 1'b0);

    // final report
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
